// File: rtl/ravenoc_axi_port_sel_pkg.sv
// Shared types for the RaveNoC AXI port selector: AXI channel bundles,
// selector FSM states and default sizing constants.
package ravenoc_axi_port_sel_pkg;

    localparam int unsigned NocSize           = 4;
    localparam int unsigned MaxOutstandingDef = 8;

    localparam int unsigned AxiAddrW = 32;
    localparam int unsigned AxiDataW = 32;
    localparam int unsigned AxiIdW   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StSwitch
    } sel_state_t;

    // Master-to-slave AXI signals (AW, W, B ready, AR, R ready)
    typedef struct packed {
        logic [AxiIdW-1:0]     awid;
        logic [AxiAddrW-1:0]   awaddr;
        logic [7:0]            awlen;
        logic [2:0]            awsize;
        logic [1:0]            awburst;
        logic                  awvalid;
        logic [AxiDataW-1:0]   wdata;
        logic [AxiDataW/8-1:0] wstrb;
        logic                  wlast;
        logic                  wvalid;
        logic                  bready;
        logic [AxiIdW-1:0]     arid;
        logic [AxiAddrW-1:0]   araddr;
        logic [7:0]            arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic                  arvalid;
        logic                  rready;
    } s_axi_mosi_t;

    // Slave-to-master AXI signals
    typedef struct packed {
        logic                awready;
        logic                wready;
        logic [AxiIdW-1:0]   bid;
        logic [1:0]          bresp;
        logic                bvalid;
        logic                arready;
        logic [AxiIdW-1:0]   rid;
        logic [AxiDataW-1:0] rdata;
        logic [1:0]          rresp;
        logic                rlast;
        logic                rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/ravenoc_axi_port_sel_if.sv
// Bundle of the selector control handshake plus the upstream and per-port AXI buses.
interface ravenoc_axi_port_sel_if #(
    parameter int unsigned NUM_PORTS = ravenoc_axi_port_sel_pkg::NocSize,
    parameter int unsigned SEL_WIDTH = $clog2(NUM_PORTS)
);
    import ravenoc_axi_port_sel_pkg::*;

    logic                 sel_req_i;
    logic [SEL_WIDTH-1:0] sel_idx_i;
    logic                 sel_busy_o;
    logic                 sel_ack_o;
    logic                 sel_err_o;
    logic [SEL_WIDTH-1:0] sel_cur_o;

    s_axi_mosi_t          s_axi_mosi_i;
    s_axi_miso_t          s_axi_miso_o;
    s_axi_mosi_t          m_axi_mosi_o [NUM_PORTS];
    s_axi_miso_t          m_axi_miso_i [NUM_PORTS];

    // Selector side
    modport slave (
        input  sel_req_i, sel_idx_i, s_axi_mosi_i, m_axi_miso_i,
        output sel_busy_o, sel_ack_o, sel_err_o, sel_cur_o, s_axi_miso_o, m_axi_mosi_o
    );

    // Environment side (upstream master, downstream NI ports, control)
    modport master (
        output sel_req_i, sel_idx_i, s_axi_mosi_i, m_axi_miso_i,
        input  sel_busy_o, sel_ack_o, sel_err_o, sel_cur_o, s_axi_miso_o, m_axi_mosi_o
    );

endinterface

// File: rtl/ravenoc_axi_ost_cnt.sv
// Outstanding-transaction counter: saturating up/down count with full and empty flags.
module ravenoc_axi_ost_cnt #(
    parameter int unsigned MAX = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic sat_o,
    output logic zero_o
);

    localparam int unsigned CntW = $clog2(MAX + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign sat_o  = (cnt_q == CntW'(MAX));
    assign zero_o = (cnt_q == '0);

    // Next count; simultaneous inc/dec cancel, both ends hold rather than wrap
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !sat_o) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && !zero_o) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Count register, synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A response with nothing outstanding means the attached port broke protocol
    underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !(dec_i && !inc_i && zero_o))
        else $error("ravenoc_axi_ost_cnt: decrement at zero");

endmodule

// File: rtl/ravenoc_axi_port_sel.sv
// Transaction-safe AXI port selector. Steers one upstream AXI master onto one of
// NUM_PORTS NI ports; port changes wait until every outstanding AW, W burst and AR
// on the current port has completed.
module ravenoc_axi_port_sel
    import ravenoc_axi_port_sel_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = NocSize,
    parameter int unsigned SEL_WIDTH       = $clog2(NUM_PORTS),
    parameter int unsigned MAX_OUTSTANDING = MaxOutstandingDef,
    parameter int unsigned RST_PORT        = 0
) (
    input  logic                   clk_axi,
    input  logic                   arst_axi,
    ravenoc_axi_port_sel_if.slave  port_sel_if
);

    localparam logic [SEL_WIDTH:0] NumPortsW = (SEL_WIDTH + 1)'(NUM_PORTS);

    sel_state_t           state_q, state_d;
    logic [SEL_WIDTH-1:0] cur_q, cur_d;
    logic [SEL_WIDTH-1:0] idx_q, idx_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;

    s_axi_mosi_t up_mosi;
    s_axi_mosi_t gated_mosi;
    s_axi_miso_t port_miso;
    s_axi_miso_t up_miso;
    s_axi_mosi_t port_mosi [NUM_PORTS];

    logic aw_open, ar_open;
    logic aw_sat, w_sat, ar_sat;
    logic aw_zero, w_zero, ar_zero;
    logic aw_hs, b_hs, wlast_hs, ar_hs, rlast_hs;

    assign up_mosi = port_sel_if.s_axi_mosi_i;

    // New address requests only flow while idle and below the outstanding limit.
    // w_sat can only assert alongside aw_sat on legal traffic; it keeps w_cnt from clipping.
    assign aw_open = (state_q == StIdle) && !aw_sat && !w_sat;
    assign ar_open = (state_q == StIdle) && !ar_sat;

    // Response mux from the currently selected port
    always_comb begin
        port_miso = '0;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            if (cur_q == SEL_WIDTH'(i)) begin
                port_miso = port_sel_if.m_axi_miso_i[i];
            end
        end
    end

    // Request demux and upstream response path with AW/AR gating; all zero during reset
    always_comb begin
        gated_mosi         = up_mosi;
        gated_mosi.awvalid = up_mosi.awvalid && aw_open;
        gated_mosi.arvalid = up_mosi.arvalid && ar_open;
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            port_mosi[i] = '0;
            if (!arst_axi && (cur_q == SEL_WIDTH'(i))) begin
                port_mosi[i] = gated_mosi;
            end
        end
        up_miso = '0;
        if (!arst_axi) begin
            up_miso         = port_miso;
            up_miso.awready = port_miso.awready && aw_open;
            up_miso.arready = port_miso.arready && ar_open;
        end
    end

    assign aw_hs    = up_mosi.awvalid && up_miso.awready;
    assign b_hs     = up_miso.bvalid && up_mosi.bready;
    assign wlast_hs = up_mosi.wvalid && up_mosi.wlast && up_miso.wready;
    assign ar_hs    = up_mosi.arvalid && up_miso.arready;
    assign rlast_hs = up_miso.rvalid && up_miso.rlast && up_mosi.rready;

    ravenoc_axi_ost_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_aw_cnt (
        .clk_i  (clk_axi),
        .rst_i  (arst_axi),
        .inc_i  (aw_hs),
        .dec_i  (b_hs),
        .sat_o  (aw_sat),
        .zero_o (aw_zero)
    );

    ravenoc_axi_ost_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_w_cnt (
        .clk_i  (clk_axi),
        .rst_i  (arst_axi),
        .inc_i  (aw_hs),
        .dec_i  (wlast_hs),
        .sat_o  (w_sat),
        .zero_o (w_zero)
    );

    ravenoc_axi_ost_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_ar_cnt (
        .clk_i  (clk_axi),
        .rst_i  (arst_axi),
        .inc_i  (ar_hs),
        .dec_i  (rlast_hs),
        .sat_o  (ar_sat),
        .zero_o (ar_zero)
    );

    // Selector FSM: accept request, drain current port, switch, acknowledge
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        idx_d   = idx_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (port_sel_if.sel_req_i) begin
                    if ({1'b0, port_sel_if.sel_idx_i} >= NumPortsW) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = port_sel_if.sel_idx_i;
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (aw_zero && w_zero && ar_zero) begin
                    state_d = StSwitch;
                end
            end
            StSwitch: begin
                cur_d   = idx_q;
                ack_d   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and selection registers, synchronous reset
    always_ff @(posedge clk_axi) begin
        if (arst_axi) begin
            state_q <= StIdle;
            cur_q   <= SEL_WIDTH'(RST_PORT);
            idx_q   <= SEL_WIDTH'(RST_PORT);
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign port_sel_if.sel_busy_o   = (state_q != StIdle);
    assign port_sel_if.sel_ack_o    = ack_q;
    assign port_sel_if.sel_err_o    = err_q;
    assign port_sel_if.sel_cur_o    = cur_q;
    assign port_sel_if.s_axi_miso_o = up_miso;
    assign port_sel_if.m_axi_mosi_o = port_mosi;

endmodule

// File: tb/tb_ravenoc_axi_port_sel.sv
// Directed bench for ravenoc_axi_port_sel: 4 ports, 3-bit index, limit of 2 outstanding.
module tb_ravenoc_axi_port_sel;
    import ravenoc_axi_port_sel_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned MO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ravenoc_axi_port_sel_if #(.NUM_PORTS(NP), .SEL_WIDTH(SW)) bus ();

    ravenoc_axi_port_sel #(
        .NUM_PORTS       (NP),
        .SEL_WIDTH       (SW),
        .MAX_OUTSTANDING (MO),
        .RST_PORT        (0)
    ) dut (
        .clk_axi     (clk),
        .arst_axi    (rst),
        .port_sel_if (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic clear_up;
        bus.s_axi_mosi_i = '0;
        bus.sel_req_i    = 1'b0;
        bus.sel_idx_i    = '0;
    endtask

    task automatic ports_idle;
        for (int i = 0; i < int'(NP); i++) begin
            bus.m_axi_miso_i[i]         = '0;
            bus.m_axi_miso_i[i].awready = 1'b1;
            bus.m_axi_miso_i[i].wready  = 1'b1;
            bus.m_axi_miso_i[i].arready = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_up();
        ports_idle();
        bus.s_axi_mosi_i.awvalid = 1'b1;
        bus.s_axi_mosi_i.awaddr  = 32'hdead_0000;
        tick();
        tick();
        checks++;
        if (bus.sel_cur_o !== 3'd0) begin
            errors++; $display("FAIL reset_cur: got %0d expected 0", bus.sel_cur_o);
        end
        checks++;
        if ({bus.sel_busy_o, bus.sel_ack_o, bus.sel_err_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/ack/err got %b%b%b expected 000",
                     bus.sel_busy_o, bus.sel_ack_o, bus.sel_err_o);
        end
        for (int p = 0; p < int'(NP); p++) begin
            checks++;
            if (bus.m_axi_mosi_o[p] !== '0) begin
                errors++; $display("FAIL reset_mosi%0d: got %h expected 0", p, bus.m_axi_mosi_o[p]);
            end
        end
        checks++;
        if (bus.s_axi_miso_o !== '0) begin
            errors++; $display("FAIL reset_miso: got %h expected 0", bus.s_axi_miso_o);
        end
        clear_up();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_datapath;
        bus.s_axi_mosi_i.awid    = 4'h3;
        bus.s_axi_mosi_i.awaddr  = 32'h0000_1000;
        bus.s_axi_mosi_i.awlen   = 8'd3;
        bus.s_axi_mosi_i.awsize  = 3'd2;
        bus.s_axi_mosi_i.awburst = 2'd1;
        bus.s_axi_mosi_i.awvalid = 1'b1;
        settle();
        checks++;
        if (bus.m_axi_mosi_o[0].awaddr !== 32'h0000_1000 || bus.m_axi_mosi_o[0].awlen !== 8'd3
            || bus.m_axi_mosi_o[0].awvalid !== 1'b1) begin
            errors++;
            $display("FAIL dp_aw: got addr %h len %0d valid %b expected 00001000 3 1",
                     bus.m_axi_mosi_o[0].awaddr, bus.m_axi_mosi_o[0].awlen,
                     bus.m_axi_mosi_o[0].awvalid);
        end
        checks++;
        if (bus.s_axi_miso_o.awready !== 1'b1) begin
            errors++; $display("FAIL dp_awready: got %b expected 1", bus.s_axi_miso_o.awready);
        end
        for (int p = 1; p < int'(NP); p++) begin
            checks++;
            if (bus.m_axi_mosi_o[p] !== '0) begin
                errors++; $display("FAIL dp_idle%0d: got %h expected 0", p, bus.m_axi_mosi_o[p]);
            end
        end
        tick();
        bus.s_axi_mosi_i.awvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.s_axi_mosi_i.wdata  = 32'ha0 + 32'(b);
            bus.s_axi_mosi_i.wstrb  = 4'hf;
            bus.s_axi_mosi_i.wvalid = 1'b1;
            bus.s_axi_mosi_i.wlast  = (b == 3);
            settle();
            if (b == 3) begin
                checks++;
                if (bus.m_axi_mosi_o[0].wdata !== 32'ha3 || bus.m_axi_mosi_o[0].wlast !== 1'b1) begin
                    errors++;
                    $display("FAIL dp_wlast: got data %h last %b expected 000000a3 1",
                             bus.m_axi_mosi_o[0].wdata, bus.m_axi_mosi_o[0].wlast);
                end
            end
            tick();
        end
        bus.s_axi_mosi_i.wvalid = 1'b0;
        bus.s_axi_mosi_i.wlast  = 1'b0;
        bus.m_axi_miso_i[0].bvalid = 1'b1;
        bus.m_axi_miso_i[0].bid    = 4'h3;
        bus.s_axi_mosi_i.bready    = 1'b1;
        settle();
        checks++;
        if (bus.s_axi_miso_o.bvalid !== 1'b1 || bus.s_axi_miso_o.bid !== 4'h3) begin
            errors++;
            $display("FAIL dp_b: got valid %b id %h expected 1 3",
                     bus.s_axi_miso_o.bvalid, bus.s_axi_miso_o.bid);
        end
        tick();
        bus.m_axi_miso_i[0].bvalid = 1'b0;
        bus.s_axi_mosi_i.bready    = 1'b0;
        bus.s_axi_mosi_i.araddr    = 32'h0000_2000;
        bus.s_axi_mosi_i.arlen     = 8'd0;
        bus.s_axi_mosi_i.arvalid   = 1'b1;
        settle();
        checks++;
        if (bus.m_axi_mosi_o[0].araddr !== 32'h0000_2000 || bus.m_axi_mosi_o[0].arvalid !== 1'b1) begin
            errors++;
            $display("FAIL dp_ar: got addr %h valid %b expected 00002000 1",
                     bus.m_axi_mosi_o[0].araddr, bus.m_axi_mosi_o[0].arvalid);
        end
        tick();
        bus.s_axi_mosi_i.arvalid   = 1'b0;
        bus.m_axi_miso_i[0].rvalid = 1'b1;
        bus.m_axi_miso_i[0].rlast  = 1'b1;
        bus.m_axi_miso_i[0].rdata  = 32'h55;
        bus.m_axi_miso_i[1].rvalid = 1'b1;
        bus.m_axi_miso_i[1].rlast  = 1'b1;
        bus.m_axi_miso_i[1].rdata  = 32'haa;
        bus.s_axi_mosi_i.rready    = 1'b1;
        settle();
        checks++;
        if (bus.s_axi_miso_o.rdata !== 32'h55 || bus.s_axi_miso_o.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL dp_r: got data %h valid %b expected 00000055 1",
                     bus.s_axi_miso_o.rdata, bus.s_axi_miso_o.rvalid);
        end
        checks++;
        if (bus.m_axi_mosi_o[1] !== '0) begin
            errors++; $display("FAIL dp_r_idle1: got %h expected 0", bus.m_axi_mosi_o[1]);
        end
        tick();
        ports_idle();
        bus.s_axi_mosi_i.rready = 1'b0;
    endtask

    task automatic test_switch_drain;
        for (int k = 0; k < 2; k++) begin
            bus.s_axi_mosi_i.awaddr  = 32'h3000 + 32'(k * 16);
            bus.s_axi_mosi_i.awlen   = 8'd0;
            bus.s_axi_mosi_i.awvalid = 1'b1;
            bus.s_axi_mosi_i.wdata   = 32'(k);
            bus.s_axi_mosi_i.wvalid  = 1'b1;
            bus.s_axi_mosi_i.wlast   = 1'b1;
            tick();
        end
        bus.s_axi_mosi_i.awaddr = 32'h3020;
        bus.s_axi_mosi_i.wvalid = 1'b0;
        bus.s_axi_mosi_i.wlast  = 1'b0;
        settle();
        checks++;
        if (bus.s_axi_miso_o.awready !== 1'b0 || bus.m_axi_mosi_o[0].awvalid !== 1'b0) begin
            errors++;
            $display("FAIL sw_limit: got awready %b awvalid %b expected 0 0",
                     bus.s_axi_miso_o.awready, bus.m_axi_mosi_o[0].awvalid);
        end
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd2;
        tick();
        bus.sel_req_i = 1'b0;
        checks++;
        if (bus.sel_busy_o !== 1'b1 || bus.sel_cur_o !== 3'd0 || bus.sel_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_busy: got busy %b cur %0d ack %b expected 1 0 0",
                     bus.sel_busy_o, bus.sel_cur_o, bus.sel_ack_o);
        end
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd5;
        tick();
        bus.sel_req_i = 1'b0;
        checks++;
        if (bus.sel_err_o !== 1'b0 || bus.sel_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL sw_drop_req: got err %b busy %b expected 0 1",
                     bus.sel_err_o, bus.sel_busy_o);
        end
        bus.m_axi_miso_i[0].bvalid = 1'b1;
        bus.s_axi_mosi_i.bready    = 1'b1;
        tick();
        tick();
        bus.m_axi_miso_i[0].bvalid = 1'b0;
        bus.s_axi_mosi_i.bready    = 1'b0;
        checks++;
        if (bus.sel_ack_o !== 1'b0 || bus.sel_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL sw_t1: got ack %b busy %b expected 0 1", bus.sel_ack_o, bus.sel_busy_o);
        end
        tick();
        checks++;
        if (bus.sel_ack_o !== 1'b0 || bus.sel_busy_o !== 1'b1 || bus.sel_cur_o !== 3'd0) begin
            errors++;
            $display("FAIL sw_t2: got ack %b busy %b cur %0d expected 0 1 0",
                     bus.sel_ack_o, bus.sel_busy_o, bus.sel_cur_o);
        end
        tick();
        checks++;
        if (bus.sel_ack_o !== 1'b1 || bus.sel_busy_o !== 1'b0 || bus.sel_cur_o !== 3'd2) begin
            errors++;
            $display("FAIL sw_t3: got ack %b busy %b cur %0d expected 1 0 2",
                     bus.sel_ack_o, bus.sel_busy_o, bus.sel_cur_o);
        end
        checks++;
        if (bus.m_axi_mosi_o[2].awvalid !== 1'b1 || bus.m_axi_mosi_o[2].awaddr !== 32'h3020
            || bus.m_axi_mosi_o[0] !== '0) begin
            errors++;
            $display("FAIL sw_pending_aw: got p2 valid %b addr %h p0 %h expected 1 00003020 0",
                     bus.m_axi_mosi_o[2].awvalid, bus.m_axi_mosi_o[2].awaddr, bus.m_axi_mosi_o[0]);
        end
        tick();
        bus.s_axi_mosi_i.awvalid = 1'b0;
        checks++;
        if (bus.sel_ack_o !== 1'b0) begin
            errors++; $display("FAIL sw_ack_pulse: got %b expected 0", bus.sel_ack_o);
        end
        bus.s_axi_mosi_i.wvalid = 1'b1;
        bus.s_axi_mosi_i.wlast  = 1'b1;
        tick();
        bus.s_axi_mosi_i.wvalid    = 1'b0;
        bus.s_axi_mosi_i.wlast     = 1'b0;
        bus.m_axi_miso_i[2].bvalid = 1'b1;
        bus.s_axi_mosi_i.bready    = 1'b1;
        tick();
        bus.m_axi_miso_i[2].bvalid = 1'b0;
        bus.s_axi_mosi_i.bready    = 1'b0;
    endtask

    task automatic test_err;
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd4;
        tick();
        bus.sel_req_i = 1'b0;
        checks++;
        if (bus.sel_err_o !== 1'b1 || bus.sel_busy_o !== 1'b0 || bus.sel_cur_o !== 3'd2) begin
            errors++;
            $display("FAIL err_pulse: got err %b busy %b cur %0d expected 1 0 2",
                     bus.sel_err_o, bus.sel_busy_o, bus.sel_cur_o);
        end
        tick();
        checks++;
        if (bus.sel_err_o !== 1'b0 || bus.sel_cur_o !== 3'd2 || bus.sel_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_after: got err %b cur %0d busy %b expected 0 2 0",
                     bus.sel_err_o, bus.sel_cur_o, bus.sel_busy_o);
        end
    endtask

    task automatic test_ar_limit;
        bus.s_axi_mosi_i.araddr  = 32'h4000;
        bus.s_axi_mosi_i.arvalid = 1'b1;
        tick();
        tick();
        settle();
        checks++;
        if (bus.s_axi_miso_o.arready !== 1'b0 || bus.m_axi_mosi_o[2].arvalid !== 1'b0) begin
            errors++;
            $display("FAIL ar_limit: got arready %b arvalid %b expected 0 0",
                     bus.s_axi_miso_o.arready, bus.m_axi_mosi_o[2].arvalid);
        end
        tick();
        bus.m_axi_miso_i[2].rvalid = 1'b1;
        bus.m_axi_miso_i[2].rlast  = 1'b1;
        bus.s_axi_mosi_i.rready    = 1'b1;
        settle();
        checks++;
        if (bus.s_axi_miso_o.arready !== 1'b0) begin
            errors++; $display("FAIL ar_hold: got arready %b expected 0", bus.s_axi_miso_o.arready);
        end
        tick();
        bus.m_axi_miso_i[2].rvalid = 1'b0;
        settle();
        checks++;
        if (bus.s_axi_miso_o.arready !== 1'b1 || bus.m_axi_mosi_o[2].arvalid !== 1'b1) begin
            errors++;
            $display("FAIL ar_reopen: got arready %b arvalid %b expected 1 1",
                     bus.s_axi_miso_o.arready, bus.m_axi_mosi_o[2].arvalid);
        end
        tick();
        bus.s_axi_mosi_i.arvalid   = 1'b0;
        bus.m_axi_miso_i[2].rvalid = 1'b1;
        tick();
        tick();
        bus.m_axi_miso_i[2].rvalid = 1'b0;
        bus.m_axi_miso_i[2].rlast  = 1'b0;
        bus.s_axi_mosi_i.rready    = 1'b0;
    endtask

    task automatic test_w_drain;
        bus.s_axi_mosi_i.awaddr  = 32'h5000;
        bus.s_axi_mosi_i.awlen   = 8'd1;
        bus.s_axi_mosi_i.awvalid = 1'b1;
        tick();
        bus.s_axi_mosi_i.awvalid = 1'b0;
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd1;
        tick();
        bus.sel_req_i = 1'b0;
        bus.s_axi_mosi_i.wdata  = 32'hb0;
        bus.s_axi_mosi_i.wvalid = 1'b1;
        bus.s_axi_mosi_i.wlast  = 1'b0;
        settle();
        checks++;
        if (bus.m_axi_mosi_o[2].wvalid !== 1'b1 || bus.m_axi_mosi_o[2].wdata !== 32'hb0) begin
            errors++;
            $display("FAIL wd_w_flows: got valid %b data %h expected 1 000000b0",
                     bus.m_axi_mosi_o[2].wvalid, bus.m_axi_mosi_o[2].wdata);
        end
        tick();
        bus.s_axi_mosi_i.wdata = 32'hb1;
        bus.s_axi_mosi_i.wlast = 1'b1;
        tick();
        bus.s_axi_mosi_i.wvalid = 1'b0;
        bus.s_axi_mosi_i.wlast  = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.sel_busy_o !== 1'b1 || bus.sel_ack_o !== 1'b0 || bus.sel_cur_o !== 3'd2) begin
            errors++;
            $display("FAIL wd_wait_b: got busy %b ack %b cur %0d expected 1 0 2",
                     bus.sel_busy_o, bus.sel_ack_o, bus.sel_cur_o);
        end
        bus.m_axi_miso_i[2].bvalid = 1'b1;
        bus.s_axi_mosi_i.bready    = 1'b1;
        tick();
        bus.m_axi_miso_i[2].bvalid = 1'b0;
        bus.s_axi_mosi_i.bready    = 1'b0;
        tick();
        checks++;
        if (bus.sel_ack_o !== 1'b0) begin
            errors++; $display("FAIL wd_early_ack: got %b expected 0", bus.sel_ack_o);
        end
        tick();
        checks++;
        if (bus.sel_ack_o !== 1'b1 || bus.sel_cur_o !== 3'd1) begin
            errors++;
            $display("FAIL wd_ack: got ack %b cur %0d expected 1 1", bus.sel_ack_o, bus.sel_cur_o);
        end
        tick();
    endtask

    task automatic test_reset_drain;
        bus.s_axi_mosi_i.awaddr  = 32'h6000;
        bus.s_axi_mosi_i.awlen   = 8'd0;
        bus.s_axi_mosi_i.awvalid = 1'b1;
        tick();
        bus.s_axi_mosi_i.awvalid = 1'b0;
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd3;
        tick();
        bus.sel_req_i = 1'b0;
        checks++;
        if (bus.sel_busy_o !== 1'b1) begin
            errors++; $display("FAIL rd_busy: got %b expected 1", bus.sel_busy_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus.sel_cur_o !== 3'd0 || bus.sel_busy_o !== 1'b0 || bus.sel_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_reset: got cur %0d busy %b ack %b expected 0 0 0",
                     bus.sel_cur_o, bus.sel_busy_o, bus.sel_ack_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.sel_cur_o !== 3'd0 || bus.sel_busy_o !== 1'b0 || bus.sel_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_after: got cur %0d busy %b ack %b expected 0 0 0",
                     bus.sel_cur_o, bus.sel_busy_o, bus.sel_ack_o);
        end
        // Counters must be clear again: a fresh request acks at minimum latency
        bus.sel_req_i = 1'b1;
        bus.sel_idx_i = 3'd1;
        tick();
        bus.sel_req_i = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.sel_ack_o !== 1'b1 || bus.sel_cur_o !== 3'd1) begin
            errors++;
            $display("FAIL rd_min_latency: got ack %b cur %0d expected 1 1",
                     bus.sel_ack_o, bus.sel_cur_o);
        end
        tick();
    endtask

    initial begin
        ports_idle();
        clear_up();
        test_reset();
        test_datapath();
        test_switch_drain();
        test_err();
        test_ar_limit();
        test_w_drain();
        test_reset_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ravenoc_axi_port_sel.md
Name: ravenoc_axi_port_sel

Overview:
- Registered, transaction-safe AXI port selector. Steers one upstream AXI slave interface (s_axi_mosi_t / s_axi_miso_t) onto one of NUM_PORTS RaveNoC NI ports.
- Successor to the combinational test-harness mux. Port changes are requested by handshake and take effect only after all outstanding write/read transactions on the current port have drained.
- Tracks outstanding AW, W-burst and AR counts, with a configurable limit. Used in SoC integration and in the cocotb top.

Parameters:
- NUM_PORTS, NOC_SIZE, number of downstream NI ports (>=2).
- SEL_WIDTH, $clog2(NUM_PORTS), width of port index.
- MAX_OUTSTANDING, 8, maximum in-flight transactions per counter (power of two not required, >=1).
- RST_PORT, 0, port selected out of reset (< NUM_PORTS).

Ports:
- clk_axi  input  1  AXI clock; only clock.
- arst_axi  input  1  reset, synchronous, active-high.
- sel_req_i  input  1  port-change request valid.
- sel_idx_i  input  SEL_WIDTH  requested port index.
- sel_busy_o  output  1  high while a change is in progress; requests ignored.
- sel_ack_o  output  1  one-cycle pulse when the new port is live.
- sel_err_o  output  1  one-cycle pulse for an out-of-range index.
- sel_cur_o  output  SEL_WIDTH  currently selected port.
- s_axi_mosi_i  input  s_axi_mosi_t  upstream requests.
- s_axi_miso_o  output  s_axi_miso_t  upstream responses.
- m_axi_mosi_o  output  s_axi_mosi_t [NUM_PORTS]  per-port requests.
- m_axi_miso_i  input  s_axi_miso_t [NUM_PORTS]  per-port responses.

Behaviour:
- **Reset** (arst_axi high at a rising edge):
  - State IDLE; sel_cur_o = RST_PORT.
  - All counters 0; sel_busy_o, sel_ack_o, sel_err_o = 0.
  - All m_axi_mosi_o = '0; s_axi_miso_o = '0 during reset.
  - Reset mid-drain abandons the change.
- **Datapath:** combinational pass-through between upstream and m_axi_mosi_o[sel_cur_o] / m_axi_miso_i[sel_cur_o], zero added latency. Non-selected ports are driven to '0. Their miso is ignored.
- **Counters:** each is MAX_OUTSTANDING-capable, width $clog2(MAX_OUTSTANDING+1).
  - aw_cnt: +1 on AW handshake, -1 on B handshake.
  - w_cnt: +1 on AW handshake, -1 on W handshake with wlast.
  - ar_cnt: +1 on AR handshake, -1 on R handshake with rlast.
  - A simultaneous inc and dec leaves the counter unchanged.
  - Decrement at 0 is a protocol violation: hold at 0 and flag via a simulation assertion.
- **Limit:** when aw_cnt == MAX_OUTSTANDING, gate awvalid to the port and awready to upstream to 0. Same for ar_cnt with arvalid/arready. W, B and R are never gated.
- **FSM:**
  - IDLE: on sel_req_i:
    - If sel_idx_i >= NUM_PORTS: pulse sel_err_o next cycle and stay IDLE.
    - Else: latch the index and go to DRAIN. sel_busy_o = 1 from the next cycle.
    - An AW/AR handshake in the same cycle as the request is counted normally.
  - DRAIN: awvalid/arvalid to the port and awready/arready upstream forced 0. W/B/R continue. When aw_cnt, w_cnt and ar_cnt are all 0, go to SWITCH.
  - SWITCH (one cycle): sel_cur_o <= latched index; sel_ack_o pulses the following cycle; sel_busy_o drops with sel_ack_o; return to IDLE.
  - Minimum request-to-ack latency is 3 cycles (request t, DRAIN t+1, SWITCH t+2, ack/new port live t+3).
  - A request for the current port follows the same path (drain + ack); there is no short-circuit.
- sel_req_i while sel_busy_o = 1 is dropped; no error is flagged.
- Upstream valids held during DRAIN remain pending and complete on the new port (AXI-legal: valid held, ready low).

Decomposition:
- ravenoc_pkg gains the sel_state_t enum (IDLE, DRAIN, SWITCH) and the MAX_OUTSTANDING default constant.
- Sub-module ravenoc_axi_ost_cnt: up/down counter with inc/dec inputs, saturation flag (cnt == MAX), zero flag and underflow assertion. Instantiated three times.
- Top handles the FSM and mux only.

Test Plan:
- Reset, then single write burst (awlen=3) and a read on port 0 → data arrives only at m_axi_mosi_o[0]; sel_cur_o=0; other ports all-zero.
- Issue 2 writes with B withheld, request port 2 → sel_busy_o=1. AW to the port gated while aw_cnt=2. Release both B → sel_ack_o exactly 3 cycles after the last B, sel_cur_o=2.
- sel_idx_i=NUM_PORTS with NUM_PORTS=4 → sel_err_o pulses 1 cycle; sel_cur_o unchanged; sel_busy_o stays 0.
- MAX_OUTSTANDING=2: 3 back-to-back ARs with R withheld → third arready stays 0 until the first rlast handshake, then is accepted.
- AW accepted, wlast not yet sent, switch requested → stays in DRAIN until wlast and B complete (w_cnt and aw_cnt reach 0); ack follows.
- Assert arst_axi during DRAIN → next cycle sel_cur_o=RST_PORT, counters 0, sel_busy_o=0, no sel_ack_o pulse.
